// File: rtl/trng_word_server_if.sv
// Word-transfer and health-status bundle between the TRNG word server and its consumer.
interface trng_word_server_if #(
   parameter int LEVEL_W = 3
);
   logic               trng_request;
   logic               trng_ready;
   logic [31:0]        random_number;
   logic               health_clr;
   logic               health_fail;
   logic [LEVEL_W-1:0] fifo_level;

   modport master (
      output trng_request, health_clr,
      input  trng_ready, random_number, health_fail, fifo_level
   );

   modport slave (
      input  trng_request, health_clr,
      output trng_ready, random_number, health_fail, fifo_level
   );
endinterface

// File: rtl/trng_word_server.sv
// Samples a ring-oscillator bit, debiases and health-checks it, packs 32-bit words
// into a small FIFO and serves them one per request/ready transfer.
//
// state  | meaning
// WARMUP | completed words are counted and discarded
// RUN    | completed words are pushed into the FIFO
// FAIL   | repetition limit hit: FIFO flushed, sampling ignored
module trng_word_server #(
   parameter int SAMPLE_DIV   = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int REP_LIMIT    = 32,
   parameter int WARMUP_WORDS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              entropy_bit,
   trng_word_server_if.slave bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam int WW = (WARMUP_WORDS > 1) ? $clog2(WARMUP_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_FAIL   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [DW-1:0] div_q, div_d;
   logic          have_first_q, have_first_d;
   logic          first_q, first_d;
   logic          prev_q, prev_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [31:0]   word_q, word_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [WW-1:0] warm_q, warm_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ready_q, ready_d;
   logic [31:0]   rnum_q, rnum_d;

   logic strobe, sample, word_done, pop, push, fail_trip;

   always_comb begin
      sync_d       = {sync_q[0], entropy_bit};
      div_d        = (div_q == '0) ? DW'(SAMPLE_DIV - 1) : div_q - DW'(1);
      state_d      = state_q;
      have_first_d = have_first_q;
      first_d      = first_q;
      prev_d       = prev_q;
      rep_d        = rep_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      warm_d       = warm_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      push         = 1'b0;

      sample    = sync_q[1];
      strobe    = (div_q == '0) && (state_q != ST_FAIL);
      word_done = (cnt_q == 6'd32);
      pop       = bus.trng_request && ready_q;
      fail_trip = (state_q != ST_FAIL) && (rep_q == RW'(REP_LIMIT));

      if (word_done) begin
         cnt_d  = '0;
         word_d = '0;
      end

      if (strobe) begin
         prev_d = sample;
         rep_d  = (rep_q != '0 && sample == prev_q) ? rep_q + RW'(1) : RW'(1);
         if (!have_first_q) begin
            have_first_d = 1'b1;
            first_d      = sample;
         end else begin
            have_first_d = 1'b0;
            // Pair 10 yields 1 and 01 yields 0: the accepted bit is the first sample.
            if (first_q != sample) begin
               word_d[cnt_q[4:0]] = first_q;
               cnt_d              = cnt_q + 6'd1;
            end
         end
      end

      case (state_q)
         ST_WARMUP: begin
            if (word_done) begin
               if (warm_q == WW'(WARMUP_WORDS - 1)) begin
                  state_d = ST_RUN;
                  warm_d  = '0;
               end else begin
                  warm_d = warm_q + WW'(1);
               end
            end
         end
         ST_RUN:  push = word_done && ((level_q != LW'(FIFO_DEPTH)) || pop);
         ST_FAIL: begin
            if (bus.health_clr) begin
               state_d = ST_WARMUP;
               warm_d  = '0;
            end
         end
         default: state_d = ST_WARMUP;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = word_q;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(push) - LW'(pop);

      // A trip overrides any push/pop in the same cycle.
      if (fail_trip || state_q == ST_FAIL) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         have_first_d = 1'b0;
         first_d      = 1'b0;
         prev_d       = 1'b0;
         rep_d        = '0;
         word_d       = '0;
         cnt_d        = '0;
      end
      if (fail_trip) begin
         state_d = ST_FAIL;
      end

      ready_d = (level_d != '0) && (state_d != ST_FAIL);
      rnum_d  = ready_d ? mem_d[rd_ptr_d] : 32'h0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WARMUP;
         sync_q       <= '0;
         div_q        <= DW'(SAMPLE_DIV - 1);
         have_first_q <= 1'b0;
         first_q      <= 1'b0;
         prev_q       <= 1'b0;
         rep_q        <= '0;
         word_q       <= '0;
         cnt_q        <= '0;
         warm_q       <= '0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         ready_q      <= 1'b0;
         rnum_q       <= '0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         div_q        <= div_d;
         have_first_q <= have_first_d;
         first_q      <= first_d;
         prev_q       <= prev_d;
         rep_q        <= rep_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         warm_q       <= warm_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         ready_q      <= ready_d;
         rnum_q       <= rnum_d;
      end
   end

   assign bus.trng_ready    = ready_q;
   assign bus.random_number = rnum_q;
   assign bus.health_fail   = (state_q == ST_FAIL);
   assign bus.fifo_level    = level_q;
endmodule

// File: tb/tb_trng_word_server.sv
// Directed bench for trng_word_server: entropy patterns aligned to the sample grid,
// expected words queued at push time and checked by a separate pop monitor.
module tb_trng_word_server;
   localparam int SAMPLE_DIV = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic entropy_bit = 1'b0;

   trng_word_server_if #(.LEVEL_W(LW)) bus ();

   trng_word_server #(
      .SAMPLE_DIV  (SAMPLE_DIV),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .REP_LIMIT   (32),
      .WARMUP_WORDS(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .entropy_bit(entropy_bit),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int ecnt = 0;
   int pops = 0;
   int pat_sel = 0;
   logic [31:0] exp_q[$];
   logic [31:0] words [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, ecnt);
      end
   endtask

   // Word table: sample j carries bit (j/2)%32 of word j/64 as a 10 or 01 pair.
   function automatic logic pat_bit(input int sel, input int j);
      logic [31:0] w;
      logic [3:0]  p;
      w = words[(j / 64) % 9];
      p = 4'b1011;
      case (sel)
         0:       pat_bit = (j % 2 == 0) ? w[(j / 2) % 32] : ~w[(j / 2) % 32];
         1:       pat_bit = 1'b1;
         default: pat_bit = p[j % 4];
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt = 0;
      else        ecnt = ecnt + 1;
   end

   always @(negedge clk) begin
      entropy_bit = pat_bit(pat_sel, rst_n ? ecnt / SAMPLE_DIV : 0);
   end

   // A pop happens on the next rising edge whenever request and ready are both high here.
   always @(negedge clk) begin
      if (rst_n && bus.trng_request && bus.trng_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got pop of %h, expected no pop", bus.random_number);
         end else begin
            check("pop_data", bus.random_number, exp_q.pop_front());
         end
      end
      if (!bus.trng_ready) check("idle_zero", bus.random_number, 32'h0);
   end

   task automatic wait_edge(input int n);
      int guard;
      guard = 0;
      while (ecnt < n && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (ecnt != n) begin
         total++;
         bad++;
         $display("FAIL wait_edge: got edge %0d expected %0d", ecnt, n);
      end
   endtask

   task automatic do_reset();
      bus.trng_request = 1'b0;
      bus.health_clr   = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic check_outs(input string name, input logic rdy, input int lvl,
                             input logic [31:0] rn, input logic hf);
      check({name, "_ready"}, 32'(bus.trng_ready), 32'(rdy));
      check({name, "_level"}, 32'(bus.fifo_level), lvl);
      check({name, "_word"}, bus.random_number, rn);
      check({name, "_hfail"}, 32'(bus.health_fail), 32'(hf));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'hFFFF_FFFF;
      words[2] = 32'hFFFF_FFFF;
      words[3] = 32'h8000_0001;
      words[4] = 32'h7FFF_FFFF;
      words[5] = 32'hA5A5_5A5A;
      words[6] = 32'h1234_5678;
      words[7] = 32'hDEAD_BEEF;
      words[8] = 32'h0F0F_F0F0;
      bus.trng_request = 1'b0;
      bus.health_clr   = 1'b0;

      // Warm-up discard, fill to full, overflow drop, burst drain, request while empty.
      pat_sel = 0;
      do_reset();
      check_outs("rst", 1'b0, 0, 32'h0, 1'b0);
      wait_edge(768);
      check_outs("warm_end", 1'b0, 0, 32'h0, 1'b0);
      wait_edge(769);
      check_outs("first_push", 1'b1, 1, 32'hFFFF_FFFF, 1'b0);
      for (int k = 2; k <= 5; k++) exp_q.push_back(words[k]);
      wait_edge(1537);
      check("full_level", 32'(bus.fifo_level), 4);
      wait_edge(1840);
      check_outs("full_hold", 1'b1, 4, words[2], 1'b0);
      bus.trng_request = 1'b1;
      wait_edge(1841);
      check("burst_level1", 32'(bus.fifo_level), 3);
      wait_edge(1844);
      check_outs("drained", 1'b0, 0, 32'h0, 1'b0);
      check("burst_pops", pops, 4);
      exp_q.push_back(words[7]);
      wait_edge(2048);
      check("req_empty_ready", 32'(bus.trng_ready), 0);
      wait_edge(2049);
      check_outs("after_drop", 1'b1, 1, words[7], 1'b0);
      wait_edge(2050);
      check_outs("single_pop", 1'b0, 0, 32'h0, 1'b0);
      check("single_pops", pops, 5);
      bus.trng_request = 1'b0;

      // Reset mid-word with one word buffered.
      wait_edge(2305);
      check_outs("pre_rst", 1'b1, 1, words[8], 1'b0);
      wait_edge(2466);
      rst_n = 1'b0;
      #2;
      check_outs("in_rst", 1'b0, 0, 32'h0, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_edge(768);
      check_outs("rewarm_end", 1'b0, 0, 32'h0, 1'b0);
      wait_edge(769);
      check_outs("rewarm_push", 1'b1, 1, words[2], 1'b0);
      exp_q.push_back(words[2]);
      exp_q.push_back(words[3]);
      wait_edge(1025);
      check("two_buffered", 32'(bus.fifo_level), 2);

      // Constant entropy trips the health test; recovery rewarms.
      wait_edge(1026);
      pat_sel = 1;
      wait_edge(1152);
      check_outs("pre_trip", 1'b1, 2, words[2], 1'b0);
      wait_edge(1153);
      check_outs("trip", 1'b0, 0, 32'h0, 1'b1);
      exp_q.delete();
      wait_edge(1200);
      pat_sel = 0;
      wait_edge(1279);
      bus.health_clr = 1'b1;
      wait_edge(1280);
      bus.health_clr = 1'b0;
      wait_edge(1281);
      check_outs("cleared", 1'b0, 0, 32'h0, 1'b0);
      wait_edge(2048);
      check("recover_warm", 32'(bus.trng_ready), 0);
      wait_edge(2049);
      check_outs("recover_push", 1'b1, 1, words[7], 1'b0);
      exp_q.push_back(words[7]);
      wait_edge(2100);
      bus.health_clr = 1'b1;
      wait_edge(2101);
      bus.health_clr = 1'b0;
      check_outs("clr_in_run", 1'b1, 1, words[7], 1'b0);
      exp_q.push_back(words[8]);
      wait_edge(2305);
      check("run_kept", 32'(bus.fifo_level), 2);
      bus.trng_request = 1'b1;
      wait_edge(2307);
      check_outs("recover_drain", 1'b0, 0, 32'h0, 1'b0);
      bus.trng_request = 1'b0;

      // Pattern 1,1,0,1: zero words at half rate, no health trip.
      pat_sel = 2;
      do_reset();
      wait_edge(1025);
      check("half_rate_1025", 32'(bus.trng_ready), 0);
      wait_edge(1536);
      check("half_rate_1536", 32'(bus.trng_ready), 0);
      wait_edge(1537);
      check_outs("zero_word", 1'b1, 1, 32'h0, 1'b0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      wait_edge(2049);
      check_outs("zero_two", 1'b1, 2, 32'h0, 1'b0);
      bus.trng_request = 1'b1;
      wait_edge(2051);
      check_outs("zero_drain", 1'b0, 0, 32'h0, 1'b0);
      bus.trng_request = 1'b0;

      check("total_pops", pops, 9);
      check("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
